// File: rtl/nem_ohmux_sel_seq_if.sv
// Request/status bundle for the NEM one-hot mux select sequencer.
// master: requester (drives REQ_*), slave: sequencer (drives status + S).
interface nem_ohmux_sel_seq_if #(
  parameter int N    = 4,
  parameter int SELW = 2
);
  logic            REQ_VALID;
  logic [SELW-1:0] REQ_SEL;
  logic            REQ_OFF;
  logic            REQ_READY;
  logic [N-1:0]    S;
  logic [SELW-1:0] CUR_SEL;
  logic            CUR_ON;
  logic            SETTLED;
  logic            ERR;

  modport master (
    output REQ_VALID,
    output REQ_SEL,
    output REQ_OFF,
    input  REQ_READY,
    input  S,
    input  CUR_SEL,
    input  CUR_ON,
    input  SETTLED,
    input  ERR
  );

  modport slave (
    input  REQ_VALID,
    input  REQ_SEL,
    input  REQ_OFF,
    output REQ_READY,
    output S,
    output CUR_SEL,
    output CUR_ON,
    output SETTLED,
    output ERR
  );
endinterface

// File: rtl/nem_ohmux_sel_seq.sv
// Break-before-make one-hot relay select sequencer for NEM inverting muxes.
// Ports: CP clock, CD async active-high reset, bus = request/status (slave).
module nem_ohmux_sel_seq #(
  parameter int N         = 4,
  parameter int SELW      = 2,
  parameter int BREAK_CYC = 3,
  parameter int MAKE_CYC  = 5,
  parameter int CNTW      = 8
) (
  input  logic               CP,
  input  logic               CD,
  nem_ohmux_sel_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BRK  = 2'd1,
    MAKE = 2'd2
  } state_e;

  localparam logic [SELW:0] N_EXT =
    (SELW+1)'(N);
  localparam logic [CNTW-1:0] BRK_LD =
    CNTW'(BREAK_CYC - 1);
  localparam logic [CNTW-1:0] MAKE_LD =
    CNTW'(MAKE_CYC - 1);
  localparam logic [N-1:0] ONE =
    {{(N-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [SELW-1:0] tgt_q, tgt_d;
  logic            tgt_vld_q, tgt_vld_d;
  logic [N-1:0]    s_q, s_d;
  logic [SELW-1:0] cur_sel_q, cur_sel_d;
  logic            cur_on_q, cur_on_d;
  logic            settled_q, settled_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;

  logic accept;
  logic sel_bad;
  logic want_off;
  logic same_sel;
  logic cnt_zero;

  always_comb begin
    accept   = bus.REQ_VALID & ready_q;
    sel_bad  = {1'b0, bus.REQ_SEL} >= N_EXT;
    // An out-of-range index degrades to
    // an open-all request.
    want_off = bus.REQ_OFF | sel_bad;
    same_sel = ~want_off & cur_on_q &
               (bus.REQ_SEL == cur_sel_q);
    cnt_zero = (cnt_q == '0);
  end

  always_ff @(posedge CP or posedge CD) begin
    if (CD) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tgt_q     <= '0;
      tgt_vld_q <= 1'b0;
      s_q       <= '0;
      cur_sel_q <= '0;
      cur_on_q  <= 1'b0;
      settled_q <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      tgt_vld_q <= tgt_vld_d;
      s_q       <= s_d;
      cur_sel_q <= cur_sel_d;
      cur_on_q  <= cur_on_d;
      settled_q <= settled_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    // Saturating down-count: holds at 0.
    cnt_d     = cnt_zero ? cnt_q
                         : cnt_q - 1'b1;
    tgt_d     = tgt_q;
    tgt_vld_d = tgt_vld_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (accept) begin
          if (want_off) begin
            if (cur_on_q) begin
              state_d   = BRK;
              tgt_vld_d = 1'b0;
              cnt_d     = BRK_LD;
            end
          end else if (!same_sel) begin
            state_d   = BRK;
            tgt_vld_d = 1'b1;
            tgt_d     = bus.REQ_SEL;
            cnt_d     = BRK_LD;
          end
        end
      end
      (state_q == BRK): begin
        if (cnt_zero) begin
          if (tgt_vld_q) begin
            state_d = MAKE;
            cnt_d   = MAKE_LD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      (state_q == MAKE): begin
        if (cnt_zero) begin
          state_d   = IDLE;
          tgt_vld_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    s_d       = s_q;
    cur_sel_d = cur_sel_q;
    cur_on_d  = cur_on_q;
    settled_d = settled_q;
    ready_d   = (state_d == IDLE);
    // REQ_OFF masks the range error.
    err_d     = accept & ~bus.REQ_OFF &
                sel_bad;
    unique case (1'b1)
      (state_d == BRK): begin
        s_d       = '0;
        cur_on_d  = 1'b0;
        settled_d = 1'b0;
      end
      (state_q == BRK &&
       state_d == MAKE): begin
        s_d       = ONE << tgt_q;
        cur_sel_d = tgt_q;
        cur_on_d  = 1'b1;
        settled_d = 1'b0;
      end
      (state_q == MAKE &&
       state_d == IDLE): begin
        settled_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.REQ_READY = ready_q;
  assign bus.S         = s_q;
  assign bus.CUR_SEL   = cur_sel_q;
  assign bus.CUR_ON    = cur_on_q;
  assign bus.SETTLED   = settled_q;
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_nem_ohmux_sel_seq.sv
// Directed bench for nem_ohmux_sel_seq: N=4 vector table plus
// N=5 hand sequences (range error, async reset mid-MAKE).
module tb_nem_ohmux_sel_seq;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  nem_ohmux_sel_seq_if #(.N(4), .SELW(2)) ifa ();
  nem_ohmux_sel_seq_if #(.N(5), .SELW(3)) ifb ();

  nem_ohmux_sel_seq #(
    .N(4), .SELW(2), .BREAK_CYC(3),
    .MAKE_CYC(5), .CNTW(8)
  ) dut_a (
    .CP(clk), .CD(rst_a), .bus(ifa)
  );

  nem_ohmux_sel_seq #(
    .N(5), .SELW(3), .BREAK_CYC(3),
    .MAKE_CYC(5), .CNTW(8)
  ) dut_b (
    .CP(clk), .CD(rst_b), .bus(ifb)
  );

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic       off;
    logic [3:0] s;
    logic       on;
    logic       set;
    logic       rdy;
    logic       err;
    logic [1:0] cur;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input logic v, input logic [1:0] sel,
    input logic off, input logic [3:0] s,
    input logic on, input logic set,
    input logic rdy, input logic err,
    input logic [1:0] cur);
    vec_t r;
    r.v = v; r.sel = sel; r.off = off;
    r.s = s; r.on = on; r.set = set;
    r.rdy = rdy; r.err = err; r.cur = cur;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name,
    input logic [31:0] act,
    input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h",
               name, act, exp);
    end
  endtask

  logic [3:0] prev_a = '0;
  logic [4:0] prev_b = '0;

  always @(negedge clk) begin
    if (!rst_a) begin
      total++;
      if ($countones(ifa.S) > 1 ||
          (prev_a != 0 && ifa.S != 0 &&
           ifa.S != prev_a)) begin
        bad++;
        $display("FAIL inv_a act=%b prev=%b",
                 ifa.S, prev_a);
      end
    end
    if (!rst_b) begin
      total++;
      if ($countones(ifb.S) > 1 ||
          (prev_b != 0 && ifb.S != 0 &&
           ifb.S != prev_b)) begin
        bad++;
        $display("FAIL inv_b act=%b prev=%b",
                 ifb.S, prev_b);
      end
    end
    prev_a <= ifa.S;
    prev_b <= ifb.S;
  end

  initial begin
    int k;
    ifa.REQ_VALID = 0;
    ifa.REQ_SEL = '0;
    ifa.REQ_OFF = 0;
    ifb.REQ_VALID = 0;
    ifb.REQ_SEL = '0;
    ifb.REQ_OFF = 0;

    // select 2 from reset
    add(1,2,0, 4'b0000,0,0,0,0,0);
    repeat (2)
      add(0,0,0, 4'b0000,0,0,0,0,0);
    repeat (5)
      add(0,0,0, 4'b0100,1,0,0,0,2);
    add(0,0,0, 4'b0100,1,1,1,0,2);
    // 2 -> 1
    add(1,1,0, 4'b0000,0,0,0,0,0);
    repeat (2)
      add(0,0,0, 4'b0000,0,0,0,0,0);
    repeat (5)
      add(0,0,0, 4'b0010,1,0,0,0,1);
    add(0,0,0, 4'b0010,1,1,1,0,1);
    // same select again: no-op
    add(1,1,0, 4'b0010,1,1,1,0,1);
    add(0,0,0, 4'b0010,1,1,1,0,1);
    // 1 -> 3, request during MAKE ignored
    add(1,3,0, 4'b0000,0,0,0,0,0);
    repeat (2)
      add(0,0,0, 4'b0000,0,0,0,0,0);
    add(0,0,0, 4'b1000,1,0,0,0,3);
    repeat (4)
      add(1,0,0, 4'b1000,1,0,0,0,3);
    add(1,0,0, 4'b1000,1,1,1,0,3);
    add(0,0,0, 4'b1000,1,1,1,0,3);
    // open all
    add(1,0,1, 4'b0000,0,0,0,0,0);
    repeat (2)
      add(0,0,0, 4'b0000,0,0,0,0,0);
    add(0,0,0, 4'b0000,0,0,1,0,0);
    // off when open: no-op; off beats sel
    add(1,0,1, 4'b0000,0,0,1,0,0);
    add(1,2,1, 4'b0000,0,0,1,0,0);
    // close from all-open still breaks
    add(1,2,0, 4'b0000,0,0,0,0,0);
    repeat (2)
      add(0,0,0, 4'b0000,0,0,0,0,0);
    add(0,0,0, 4'b0100,1,0,0,0,2);

    repeat (3) begin
      @(negedge clk);
      chk("rst_s", ifa.S, 0);
      chk("rst_on", ifa.CUR_ON, 0);
      chk("rst_set", ifa.SETTLED, 0);
      chk("rst_rdy", ifa.REQ_READY, 0);
      chk("rst_err", ifa.ERR, 0);
      chk("rst_cur", ifa.CUR_SEL, 0);
      chk("rst_rdy_b", ifb.REQ_READY, 0);
      chk("rst_s_b", ifb.S, 0);
    end
    rst_a = 0;
    rst_b = 0;
    @(negedge clk);
    chk("rdy_post_rst", ifa.REQ_READY, 1);
    chk("rdy_post_rst_b", ifb.REQ_READY, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      ifa.REQ_VALID = tbl[i].v;
      ifa.REQ_SEL = tbl[i].sel;
      ifa.REQ_OFF = tbl[i].off;
      @(negedge clk);
      chk($sformatf("v%0d_s", i),
          ifa.S, tbl[i].s);
      chk($sformatf("v%0d_on", i),
          ifa.CUR_ON, tbl[i].on);
      chk($sformatf("v%0d_set", i),
          ifa.SETTLED, tbl[i].set);
      chk($sformatf("v%0d_rdy", i),
          ifa.REQ_READY, tbl[i].rdy);
      chk($sformatf("v%0d_err", i),
          ifa.ERR, tbl[i].err);
      if (tbl[i].on)
        chk($sformatf("v%0d_cur", i),
            ifa.CUR_SEL, tbl[i].cur);
    end
    ifa.REQ_VALID = 0;
    ifa.REQ_OFF = 0;

    // A is now mid-MAKE: async reset
    #2 rst_a = 1;
    #1;
    chk("a_async_s", ifa.S, 0);
    chk("a_async_on", ifa.CUR_ON, 0);
    chk("a_async_rdy", ifa.REQ_READY, 0);
    @(negedge clk);
    chk("a_hold_s", ifa.S, 0);
    rst_a = 0;
    @(negedge clk);
    chk("a_rel_rdy", ifa.REQ_READY, 1);
    chk("a_rel_s", ifa.S, 0);
    chk("a_rel_on", ifa.CUR_ON, 0);

    // N=5: out-of-range while open
    ifb.REQ_VALID = 1;
    ifb.REQ_SEL = 3'd6;
    @(negedge clk);
    chk("b_err1", ifb.ERR, 1);
    chk("b_err1_s", ifb.S, 0);
    chk("b_err1_on", ifb.CUR_ON, 0);
    chk("b_err1_rdy", ifb.REQ_READY, 1);
    ifb.REQ_VALID = 0;
    @(negedge clk);
    chk("b_err1_pulse", ifb.ERR, 0);

    // close input 4
    ifb.REQ_VALID = 1;
    ifb.REQ_SEL = 3'd4;
    @(negedge clk);
    chk("b_sel4_brk", ifb.S, 0);
    chk("b_sel4_rdy", ifb.REQ_READY, 0);
    chk("b_sel4_err", ifb.ERR, 0);
    ifb.REQ_VALID = 0;
    repeat (2) @(negedge clk);
    chk("b_sel4_brk3", ifb.S, 0);
    @(negedge clk);
    chk("b_sel4_s", ifb.S, 5'b10000);
    chk("b_sel4_cur", ifb.CUR_SEL, 4);
    repeat (4) @(negedge clk);
    chk("b_sel4_nset", ifb.SETTLED, 0);
    @(negedge clk);
    chk("b_sel4_set", ifb.SETTLED, 1);
    chk("b_sel4_rdy2", ifb.REQ_READY, 1);

    // out-of-range while closed: opens
    ifb.REQ_VALID = 1;
    ifb.REQ_SEL = 3'd6;
    @(negedge clk);
    chk("b_err2", ifb.ERR, 1);
    chk("b_err2_s", ifb.S, 0);
    chk("b_err2_on", ifb.CUR_ON, 0);
    chk("b_err2_rdy", ifb.REQ_READY, 0);
    ifb.REQ_VALID = 0;
    @(negedge clk);
    chk("b_err2_pulse", ifb.ERR, 0);
    repeat (2) @(negedge clk);
    chk("b_err2_idle", ifb.REQ_READY, 1);
    chk("b_err2_s2", ifb.S, 0);
    chk("b_err2_set", ifb.SETTLED, 0);

    // off with bad sel: no ERR
    ifb.REQ_VALID = 1;
    ifb.REQ_OFF = 1;
    @(negedge clk);
    chk("b_off_err", ifb.ERR, 0);
    chk("b_off_rdy", ifb.REQ_READY, 1);
    ifb.REQ_VALID = 0;
    ifb.REQ_OFF = 0;

    // async reset mid-MAKE on B
    ifb.REQ_VALID = 1;
    ifb.REQ_SEL = 3'd1;
    @(negedge clk);
    ifb.REQ_VALID = 0;
    k = 0;
    while (ifb.S == 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("b_make_reached", ifb.S, 5'b00010);
    #3 rst_b = 1;
    #1;
    chk("b_async_s", ifb.S, 0);
    chk("b_async_on", ifb.CUR_ON, 0);
    chk("b_async_set", ifb.SETTLED, 0);
    @(negedge clk);
    rst_b = 0;
    @(negedge clk);
    chk("b_rel_rdy", ifb.REQ_READY, 1);
    chk("b_rel_s", ifb.S, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
